stopwatch_core: RTL and testbench

Parametrised stopwatch/timer core for the Basys3 stopwatch design. It contains a prescaler that generates a count tick from `clk`, and an N-digit BCD chain with a per-digit radix of 6 or 10. It counts up or down, supports start/stop, clear and preload, and detects rollover and expiry. It sits between the debounced button logic and the seven-segment display driver.

---
 rtl/stopwatch_core.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_core.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch/timer core: prescaled count tick driving a mixed-radix BCD chain with run/stop/expire control.
// Optional lap/freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int                    TICK_DIV    = 10_000_000,
  parameter int                    NUM_DIGITS  = 4,
  parameter logic [NUM_DIGITS-1:0] RADIX6_MASK = 4'b0100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    dir,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    tick,
  output logic                    rollover,
  output logic                    done,
  output logic                    lap_active
);

  localparam int            CW         = 4 * NUM_DIGITS;
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {STOPPED, RUN, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] stepped;
  logic [CW-1:0] digits_nxt;
  logic          at_last;
  logic          tick_evt;
  logic          expire;
  logic          wrap_up;

  function automatic logic [3:0] digit_max(input int i);
    return RADIX6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [CW-1:0] sat_load(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > digit_max(i)) ? digit_max(i) : v[4*i +: 4];
    return r;
  endfunction

  function automatic logic all_max(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      r = r && (v[4*i +: 4] == digit_max(i));
    return r;
  endfunction

  // Ripple carry/borrow: a digit moves only when every lower digit sits at its wrap boundary.
  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic down);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (down) r[4*i +: 4] = (d == 4'd0) ? digit_max(i) : d - 4'd1;
        else      r[4*i +: 4] = (d == digit_max(i)) ? 4'd0 : d + 4'd1;
      end
      carry = carry && (down ? (d == 4'd0) : (d == digit_max(i)));
    end
    return r;
  endfunction

  // A down tick at an all-zero count (reachable after an up rollover or a zero load) expires without wrapping.
  always_comb begin
    at_last   = (presc == PRESC_LAST);
    tick_evt  = (state == RUN) && at_last && !clear && !load;
    stepped   = (dir && (count == '0)) ? count : bcd_step(count, dir);
    expire    = tick_evt && dir && (stepped == '0);
    wrap_up   = tick_evt && !dir && all_max(count);
    count_nxt = count;
    if (clear)         count_nxt = '0;
    else if (load)     count_nxt = sat_load(load_val);
    else if (tick_evt) count_nxt = stepped;
  end

`ifdef STOPWATCH_LAP_EN
  logic [CW-1:0] lap_count;
  logic [CW-1:0] lap_nxt;
  logic          lap_on_nxt;

  always_comb begin
    lap_on_nxt = lap_active;
    lap_nxt    = lap_count;
    if (clear) begin
      lap_on_nxt = 1'b0;
    end else if (lap && (state == RUN)) begin
      lap_on_nxt = !lap_active;
      if (!lap_active) lap_nxt = count;
    end
    digits_nxt = lap_on_nxt ? lap_nxt : count_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_count  <= '0;
      lap_active <= 1'b0;
    end else begin
      lap_count  <= lap_nxt;
      lap_active <= lap_on_nxt;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign digits_nxt = count_nxt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= STOPPED;
      presc    <= '0;
      count    <= '0;
      digits   <= '0;
      running  <= 1'b0;
      tick     <= 1'b0;
      rollover <= 1'b0;
      done     <= 1'b0;
    end else begin
      count    <= count_nxt;
      digits   <= digits_nxt;
      tick     <= tick_evt;
      rollover <= wrap_up;

      // Prescaler only moves in RUN so a pause keeps the partial period.
      if (clear || load)       presc <= '0;
      else if (state == RUN)   presc <= at_last ? '0 : presc + 1'b1;

      if (clear) begin
        state   <= STOPPED;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (load) begin
        if (state == EXPIRED) begin
          state <= STOPPED;
          done  <= 1'b0;
        end
      end else begin
        case (state)
          STOPPED: begin
            if (start_stop && !(dir && (count == '0))) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (expire) begin
              state   <= EXPIRED;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (start_stop) begin
              state   <= STOPPED;
              running <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: directed scenarios plus random traffic checked against an integer-valued model.
// Lap expectations follow STOPWATCH_LAP_EN when it is defined.
module tb_stopwatch_core;

  localparam int         TD   = 4;
  localparam int         ND   = 4;
  localparam logic [3:0] MASK = 4'b0100;
  localparam int ST_STOP = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_EXP  = 2;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        tick;
    logic        rollover;
    logic        done;
    logic        lap_active;
  } stat_t;

  logic        clk = 1'b0;
  logic        reset, start_stop, clear, load, dir, lap;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        running, tick, rollover, done, lap_active;

  stopwatch_core #(.TICK_DIV(TD), .NUM_DIGITS(ND), .RADIX6_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .lap(lap), .digits(digits), .running(running),
    .tick(tick), .rollover(rollover), .done(done), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    dut_ticks = 0;
  bit    mon_en = 0;
  stat_t stat_q[$];
  stat_t tick_q[$];

  // Reference state: the count is a plain integer in the mixed-radix range [0, mod_all).
  int m_st, m_pre, m_val, m_lapval, mod_all;
  bit m_lapon;

  function automatic int radix(input int i);
    return MASK[i] ? 6 : 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return r;
  endfunction

  function automatic int from_bcd_sat(input logic [15:0] b);
    int v, d;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > radix(i) - 1) d = radix(i) - 1;
      v = v * radix(i) + d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_STOP; m_pre = 0; m_val = 0; m_lapval = 0; m_lapon = 0;
  endtask

  task automatic model_step(input bit ss, input bit clr, input bit ld, input logic [15:0] lv,
                            input logic d, input bit lp);
    stat_t e;
    int    ost, oval;
    bit    te, hit0;
    ost = m_st; oval = m_val; te = 0; hit0 = 0;
    e = '0;
    if (clr) begin
      m_val = 0; m_pre = 0; m_st = ST_STOP;
    end else if (ld) begin
      m_val = from_bcd_sat(lv); m_pre = 0;
      if (m_st == ST_EXP) m_st = ST_STOP;
    end else begin
      te = (m_st == ST_RUN) && (m_pre == TD - 1);
      if (m_st == ST_RUN) m_pre = (m_pre + 1) % TD;
      if (te) begin
        e.tick = 1'b1;
        if (!d) begin
          e.rollover = (m_val == mod_all - 1);
          m_val = (m_val + 1) % mod_all;
        end else begin
          if (m_val > 0) m_val = m_val - 1;
          hit0 = (m_val == 0);
        end
      end
      if (m_st == ST_STOP) begin
        if (ss && !(d && m_val == 0)) m_st = ST_RUN;
      end else if (m_st == ST_RUN) begin
        if (hit0) m_st = ST_EXP;
        else if (ss) m_st = ST_STOP;
      end
    end
`ifdef STOPWATCH_LAP_EN
    if (clr) m_lapon = 0;
    else if (lp && ost == ST_RUN) begin
      if (m_lapon) m_lapon = 0;
      else begin m_lapon = 1; m_lapval = oval; end
    end
`else
    if (lp || ost < 0) m_lapon = 0;
`endif
    e.digits     = m_lapon ? to_bcd(m_lapval) : to_bcd(m_val);
    e.running    = (m_st == ST_RUN);
    e.done       = (m_st == ST_EXP);
    e.lap_active = m_lapon;
    stat_q.push_back(e);
    if (e.tick) tick_q.push_back(e);
  endtask

  task automatic step(input bit ss, input bit clr, input bit ld, input logic [15:0] lv, input bit lp);
    @(negedge clk);
    start_stop = ss; clear = clr; load = ld; load_val = lv; lap = lp;
    model_step(ss, clr, ld, lv, dir, lp);
    mon_en = 1;
    @(posedge clk);
    #2;
    start_stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0000, 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    #1 reset = 0;
    #1 chk("async_reset", 32'({digits, running, tick, rollover, done, lap_active}), 32'h0);
    model_reset();
    stat_q.delete();
    tick_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  always @(posedge clk) begin
    stat_t e, t;
    #1;
    if (mon_en) begin
      if (tick) dut_ticks++;
      if (stat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_queue: DUT output with no expected entry");
      end else begin
        e = stat_q.pop_front();
        chk("status", 32'({digits, running, tick, rollover, done, lap_active}), 32'(e));
      end
      if (tick) begin
        if (tick_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tick: tick with digits 0x%0h, none expected", digits);
        end else begin
          t = tick_q.pop_front();
          chk("tick_event", 32'({digits, rollover, running, done}),
              32'({t.digits, t.rollover, t.running, t.done}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    mod_all = 1;
    for (int i = 0; i < ND; i++) mod_all = mod_all * radix(i);
    reset = 0; start_stop = 0; clear = 0; load = 0; dir = 0; lap = 0; load_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 32'({digits, running, tick, rollover, done, lap_active}), 32'h0);
    @(negedge clk);
    reset = 1;

    // Plain up count.
    t0 = dut_ticks;
    step(1, 0, 0, 16'h0, 0);
    chk("start_running", 32'(running), 32'd1);
    repeat (40) idle();
    chk("count40_digits", 32'(digits), 32'h0010);
    chk("count40_ticks", 32'(dut_ticks - t0), 32'd10);
    chk("count40_running", 32'(running), 32'd1);
    step(1, 0, 0, 16'h0, 0);

    // Rollover from all-max.
    step(0, 0, 1, 16'h9599, 0);
    step(1, 0, 0, 16'h0, 0);
    repeat (3) idle();
    chk("pre_roll_tick", 32'(tick), 32'd0);
    idle();
    chk("rollover_digits", 32'(digits), 32'h0000);
    chk("rollover_pulse", 32'(rollover), 32'd1);
    idle();
    chk("rollover_single", 32'(rollover), 32'd0);
    step(1, 0, 0, 16'h0, 0);

    // Down count with borrow through the radix-6 digit.
    dir = 1;
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 1, 16'h1000, 0);
    step(1, 0, 0, 16'h0, 0);
    repeat (4) idle();
    chk("down_borrow", 32'(digits), 32'h0599);
    step(0, 1, 0, 16'h0, 0);

    // Expiry.
    step(0, 0, 1, 16'h0002, 0);
    step(1, 0, 0, 16'h0, 0);
    repeat (8) idle();
    chk("expire_digits", 32'(digits), 32'h0000);
    chk("expire_done", 32'(done), 32'd1);
    chk("expire_running", 32'(running), 32'd0);
    t0 = dut_ticks;
    repeat (8) idle();
    step(1, 0, 0, 16'h0, 0);
    chk("expired_no_ticks", 32'(dut_ticks - t0), 32'd0);
    chk("expired_ignores_start", 32'({running, done}), 32'b01);
    step(0, 1, 0, 16'h0, 0);
    chk("clear_leaves_expired", 32'(done), 32'd0);

    // Pause keeps partial prescaler period.
    dir = 0;
    step(1, 0, 0, 16'h0, 0);
    repeat (5) idle();
    step(1, 0, 0, 16'h0, 0);
    repeat (100) idle();
    step(1, 0, 0, 16'h0, 0);
    idle();
    chk("resume_tick_early", 32'(tick), 32'd0);
    idle();
    chk("resume_tick_at2", 32'(tick), 32'd1);

    // Same-cycle clear/load/start priority, then async reset mid-run.
    repeat (3) idle();
    step(1, 1, 1, 16'h1234, 0);
    chk("priority_digits", 32'(digits), 32'h0000);
    chk("priority_running", 32'(running), 32'd0);
    step(1, 0, 0, 16'h0, 0);
    repeat (10) idle();
    do_reset();

    // Lap freeze.
    step(1, 0, 0, 16'h0, 0);
    repeat (60) idle();
    chk("lap_pre_digits", 32'(digits), 32'h0015);
    step(0, 0, 0, 16'h0, 1);
    repeat (19) idle();
`ifdef STOPWATCH_LAP_EN
    chk("lap_hold_digits", 32'(digits), 32'h0015);
    chk("lap_hold_active", 32'(lap_active), 32'd1);
`else
    chk("lap_hold_digits", 32'(digits), 32'h0020);
    chk("lap_hold_active", 32'(lap_active), 32'd0);
`endif
    step(0, 0, 0, 16'h0, 1);
    chk("lap_release_digits", 32'(digits), 32'h0020);
    chk("lap_release_active", 32'(lap_active), 32'd0);
    step(0, 1, 0, 16'h0, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          ss, clr, ld, lp;
      logic [15:0] lv;
      if (n == 1500) do_reset();
      if ($urandom_range(0, 99) < 3) dir = ~dir;
      ss  = ($urandom_range(0, 99) < 8);
      clr = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 99) < 3);
      lv  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      lp  = ($urandom_range(0, 99) < 3);
      step(ss, clr, ld, lv, lp);
    end

    chk("tick_queue_drained", 32'(tick_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
